// File: rtl/aes_pkg.sv
// AES helpers shared by the iterative core: block width, legal round counts,
// FSM state type and the byte-level transforms (S-box, xtime, MixColumns, ShiftRows).
package aes_pkg;
   localparam int AES_BLK_W = 128;
   localparam int NR_AES128 = 10;
   localparam int NR_AES192 = 12;
   localparam int NR_AES256 = 14;

   typedef logic [AES_BLK_W-1:0] aes_blk_t;
   typedef enum logic [1:0] {IDLE, ROUND, HOLD} aes_state_e;

   // Forward S-box; entry 0 occupies the top byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sbox(input logic [7:0] a);
      return SBOX_TBL[2047 - 8*int'(a) -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Byte i lives at bits [127-8i -: 8]; byte (row r, col c) is index 4c+r.
   function automatic aes_blk_t shift_rows(input aes_blk_t s);
      aes_blk_t o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      return o;
   endfunction
endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped on the
// final round), AddRoundKey.
module aes_round_comb
   import aes_pkg::*;
(
   input  aes_blk_t st,
   input  aes_blk_t rk,
   input  logic     final_rnd,
   output aes_blk_t st_next
);
   aes_blk_t sb, sr, mc;

   always_comb begin
      sb = '0;
      for (int i = 0; i < 16; i++)
         sb[127-8*i -: 8] = sbox(st[127-8*i -: 8]);
      sr = shift_rows(sb);
      mc = '0;
      for (int c = 0; c < 4; c++)
         mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
      st_next = (final_rnd ? sr : mc) ^ rk;
   end
endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryption core: one round engine reused NR times, one block in flight.
// Defining AES_CBC_CHAIN_EN adds iv_load/iv and a CBC chaining register.
module aes_encrypt_iter
   import aes_pkg::*;
#(
   parameter int NR       = NR_AES128,
   parameter int RK_IDX_W = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [0:127]        plain_text,
   output logic [RK_IDX_W-1:0] rk_idx,
   input  logic [0:127]        rk_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [0:127]        cipher_text
`ifdef AES_CBC_CHAIN_EN
   ,
   input  logic                iv_load,
   input  logic [0:127]        iv
`endif
);
   if (!(NR == NR_AES128 || NR == NR_AES192 || NR == NR_AES256)) begin : g_bad_nr
      $error("aes_encrypt_iter: NR must be 10, 12 or 14");
   end
   if ((2**RK_IDX_W) <= NR) begin : g_bad_idx_w
      $error("aes_encrypt_iter: RK_IDX_W too narrow for NR");
   end

   aes_state_e          state_q, state_d;
   logic [RK_IDX_W-1:0] rnd_q, rnd_d;
   aes_blk_t            st_q, st_d, ct_q, ct_d, rnd_out, blk_in;
   logic                ov_q, ov_d, accept, last_rnd;

   aes_round_comb u_round (
      .st        (st_q),
      .rk        (rk_data),
      .final_rnd (last_rnd),
      .st_next   (rnd_out)
   );

   assign last_rnd    = (rnd_q == RK_IDX_W'(NR));
   // A new block can enter when idle, or in the same cycle the held result is taken.
   assign in_ready    = reset & ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
   assign accept      = in_valid & in_ready;
   assign rk_idx      = (state_q == ROUND) ? rnd_q : '0;
   assign out_valid   = ov_q;
   assign cipher_text = ct_q;

`ifdef AES_CBC_CHAIN_EN
   aes_blk_t chain_q, chain_d, chain_in;
   // iv_load is honoured exactly when a block could be accepted, so it can ride along.
   assign chain_in = (iv_load & in_ready) ? aes_blk_t'(iv) : chain_q;
   assign blk_in   = plain_text ^ chain_in ^ rk_data;
`else
   assign blk_in   = plain_text ^ rk_data;
`endif

   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      st_d    = st_q;
      ct_d    = ct_q;
      ov_d    = ov_q;
`ifdef AES_CBC_CHAIN_EN
      chain_d = chain_in;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               st_d    = blk_in;
               rnd_d   = RK_IDX_W'(1);
               state_d = ROUND;
            end
         end
         ROUND: begin
            st_d  = rnd_out;
            rnd_d = rnd_q + 1'b1;
            if (last_rnd) begin
               ct_d    = rnd_out;
               ov_d    = 1'b1;
               rnd_d   = '0;
               state_d = HOLD;
`ifdef AES_CBC_CHAIN_EN
               chain_d = rnd_out;
`endif
            end
         end
         HOLD: begin
            if (out_ready) begin
               ov_d = 1'b0;
               if (accept) begin
                  st_d    = blk_in;
                  rnd_d   = RK_IDX_W'(1);
                  state_d = ROUND;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         rnd_q   <= '0;
         st_q    <= '0;
         ct_q    <= '0;
         ov_q    <= 1'b0;
`ifdef AES_CBC_CHAIN_EN
         chain_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         st_q    <= st_d;
         ct_q    <= ct_d;
         ov_q    <= ov_d;
`ifdef AES_CBC_CHAIN_EN
         chain_q <= chain_d;
`endif
      end
   end
endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter: an NR=10 and an NR=14 instance, a key
// store built from the FIPS-197 key expansion, and an output scoreboard.
module tb_aes_encrypt_iter;
   import aes_pkg::sbox;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid [2];
   logic         in_ready_w [2];
   logic [127:0] pt_r [2];
   logic [3:0]   rki [2];
   logic [127:0] rkd [2];
   logic         out_valid_w [2];
   logic         out_ready_r [2];
   logic [127:0] ct_w [2];
   logic         iv_load [2];
   logic [127:0] iv_r [2];
   logic [127:0] ks [2][16];

   int checks = 0;
   int errors = 0;

   typedef struct { int d; logic [127:0] ct; } sb_t;
   sb_t exp_q [$];

   typedef struct {
      int           d;
      logic [255:0] key;
      int           nk;
      logic [127:0] pt;
      logic [127:0] ct;
   } vec_t;
   vec_t vecs [4];

   always #5 clk = ~clk;

   assign rkd[0] = ks[0][rki[0]];
   assign rkd[1] = ks[1][rki[1]];

   aes_encrypt_iter #(.NR(10), .RK_IDX_W(4)) dut10 (
      .clk(clk), .reset(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
      .plain_text(pt_r[0]), .rk_idx(rki[0]), .rk_data(rkd[0]), .out_valid(out_valid_w[0]),
      .out_ready(out_ready_r[0]), .cipher_text(ct_w[0])
`ifdef AES_CBC_CHAIN_EN
      , .iv_load(iv_load[0]), .iv(iv_r[0])
`endif
   );

   aes_encrypt_iter #(.NR(14), .RK_IDX_W(4)) dut14 (
      .clk(clk), .reset(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
      .plain_text(pt_r[1]), .rk_idx(rki[1]), .rk_data(rkd[1]), .out_valid(out_valid_w[1]),
      .out_ready(out_ready_r[1]), .cipher_text(ct_w[1])
`ifdef AES_CBC_CHAIN_EN
      , .iv_load(iv_load[1]), .iv(iv_r[1])
`endif
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp_v);
      end
   endtask

   // FIPS-197 key expansion; a 128-bit key sits in the upper half of key.
   task automatic load_key(input int d, input logic [255:0] key, input int nk);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      int          total;
      rc    = 8'h01;
      total = 4 * (nk + 7);
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < total; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = {t[23:0], t[31:24]};
            t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (nk > 6 && i % nk == 4) begin
            t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int k = 0; k < 16; k++)
         ks[d][k] = (k <= nk + 6) ? {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]} : 128'h0;
   endtask

   // Offer a block, wait for accept, expect out_valid exactly nr edges later.
   task automatic send(input int d, input logic [127:0] pt, input logic [127:0] ct,
                       input int nr, input logic ld, input logic [127:0] ivv, output int waitc);
      int  lat;
      sb_t e;
      lat   = 0;
      waitc = 0;
      in_valid[d] = 1'b1;
      pt_r[d]     = pt;
      iv_load[d]  = ld;
      iv_r[d]     = ivv;
      @(negedge clk);
      while (!in_ready_w[d] && waitc < 50) begin
         @(negedge clk);
         waitc++;
      end
      chk("accept", {127'h0, in_ready_w[d]}, 128'h1);
      e.d  = d;
      e.ct = ct;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid[d] = 1'b0;
      iv_load[d]  = 1'b0;
      while (!out_valid_w[d] && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", 128'(lat), 128'(nr));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain", 128'(exp_q.size()), 128'h0);
   endtask

   // Scoreboard: a transfer happens at the next edge when valid and ready are both high.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < 2; d++) begin
            if (out_valid_w[d] && out_ready_r[d]) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected out_valid", 128'(d + 1), 128'h0);
               end else begin
                  sb_t e;
                  e = exp_q.pop_front();
                  chk("out instance", 128'(d), 128'(e.d));
                  chk("cipher_text", ct_w[d], e.ct);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          w;
      logic [127:0] key_b, key_c1, pt_c, ct_b, ct_c1, p1;
      key_b  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      key_c1 = 128'h000102030405060708090a0b0c0d0e0f;
      pt_c   = 128'h00112233445566778899aabbccddeeff;
      ct_b   = 128'h3925841d02dc09fbdc118597196a0b32;
      ct_c1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      p1     = 128'h6bc1bee22e409f96e93d7e117393172a;

      vecs[0] = '{0, {key_b, 128'h0}, 4, 128'h3243f6a8885a308d313198a2e0370734, ct_b};
      vecs[1] = '{0, {key_c1, 128'h0}, 4, pt_c, ct_c1};
      vecs[2] = '{1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  8, pt_c, 128'h8ea2b7ca516745bfeafc49904b496089};
      vecs[3] = '{0, {key_b, 128'h0}, 4, p1, 128'h3ad77bb40d7a3660a89ecaf32466ef97};

      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         in_valid[d] = 1'b0; pt_r[d] = '0; out_ready_r[d] = 1'b1;
         iv_load[d] = 1'b0; iv_r[d] = '0;
         for (int k = 0; k < 16; k++) ks[d][k] = '0;
      end
      #3;
      for (int d = 0; d < 2; d++) begin
         chk("reset in_ready", {127'h0, in_ready_w[d]}, 128'h0);
         chk("reset out_valid", {127'h0, out_valid_w[d]}, 128'h0);
         chk("reset cipher_text", ct_w[d], 128'h0);
         chk("reset rk_idx", 128'(rki[d]), 128'h0);
      end
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk("idle in_ready", {127'h0, in_ready_w[d]}, 128'h1);
      @(posedge clk); #1;

      // Known-answer vectors: in the CBC build, iv=0 rides with the accept for plain ECB.
      for (int v = 0; v < 4; v++) begin
         load_key(vecs[v].d, vecs[v].key, vecs[v].nk);
         send(vecs[v].d, vecs[v].pt, vecs[v].ct, vecs[v].nk + 6, 1'b1, 128'h0, w);
         drain();
         @(posedge clk); #1;
      end

      // Backpressure: result must hold and in_ready stay low while out_ready=0.
      out_ready_r[0] = 1'b0;
      send(0, 128'h3243f6a8885a308d313198a2e0370734, ct_b, 10, 1'b1, 128'h0, w);
      in_valid[0] = 1'b1;
      pt_r[0]     = 128'hdeadbeef_00000000_cafef00d_12345678;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp out_valid", {127'h0, out_valid_w[0]}, 128'h1);
         chk("bp cipher_text", ct_w[0], ct_b);
         chk("bp in_ready", {127'h0, in_ready_w[0]}, 128'h0);
      end
      @(posedge clk); #1;
      out_ready_r[0] = 1'b1;
      send(0, p1, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 10, 1'b1, 128'h0, w);
      chk("same-cycle accept wait", 128'(w), 128'h0);
      drain();
      @(posedge clk); #1;

      // Reset in the middle of a block: outputs clear at once, no output for that block.
      load_key(0, {key_c1, 128'h0}, 4);
      in_valid[0] = 1'b1;
      pt_r[0]     = pt_c;
      @(negedge clk);
      chk("mid accept", {127'h0, in_ready_w[0]}, 128'h1);
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("mid rk_idx before reset", 128'(rki[0]), 128'h5);
      rst_n = 1'b0;
      #1;
      chk("mid in_ready", {127'h0, in_ready_w[0]}, 128'h0);
      chk("mid out_valid", {127'h0, out_valid_w[0]}, 128'h0);
      chk("mid cipher_text", ct_w[0], 128'h0);
      chk("mid rk_idx", 128'(rki[0]), 128'h0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("post-reset in_ready", {127'h0, in_ready_w[0]}, 128'h1);
         chk("post-reset out_valid", {127'h0, out_valid_w[0]}, 128'h0);
      end
      @(posedge clk); #1;
      send(0, pt_c, ct_c1, 10, 1'b0, 128'h0, w);
      drain();
      @(posedge clk); #1;

`ifdef AES_CBC_CHAIN_EN
      load_key(0, {key_b, 128'h0}, 4);
      send(0, p1, 128'h7649abac8119b246cee98e9b12e9197d, 10, 1'b1,
           128'h000102030405060708090a0b0c0d0e0f, w);
      drain();
      @(posedge clk); #1;
      send(0, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'h5086cb9b507219ee95db113a917678b2,
           10, 1'b0, 128'h0, w);
      drain();
      @(posedge clk); #1;
`endif

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
